// File: rtl/exec_pkg.sv
// Shared opcode encodings, FSM state type and defaults for the execute stage.
// Imported by exec_mul_seq and execute_stage.
package exec_pkg;

  localparam int EXEC_WIDTH = 8;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_MUL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_t;

  // Signed overflow of a + b given the three sign bits.
  function automatic logic add_overflow(input logic sign_a, input logic sign_b, input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH bits only.
// done flags the final iteration; p then carries the finished product for capture.
module exec_mul_seq
  import exec_pkg::*;
#(
  parameter int WIDTH = EXEC_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(ITERS + 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_p_next;
  logic             w_last;

  always_comb begin
    w_p_next = r_p + (r_b[0] ? r_a : {WIDTH{1'b0}});
    w_last   = r_busy && (r_cnt == CW'(ITERS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_p    <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_busy <= 1'b0;
    end else if (start && !r_busy) begin
      r_a    <= a;
      r_b    <= b;
      r_p    <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_p    <= w_p_next;
      r_a    <= r_a << 1;
      r_b    <= r_b >> 1;
      r_cnt  <= r_cnt + CW'(1);
      r_busy <= !w_last;
    end
  end

  assign busy = r_busy;
  assign done = w_last;
  assign p    = w_p_next;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand mux, single-cycle ALU, iterative MUL with fetch hold, registered results.
// Optional EXEC_SAT_EN: ADD/SUB clamp to the signed range on overflow instead of wrapping.
module execute_stage
  import exec_pkg::*;
#(
  parameter int WIDTH     = EXEC_WIDTH,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic             selectConst,
  input  logic             writeBack_in,
  input  logic [7:0]       dest_in,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] const_in,
  output logic             hold,
  output logic             out_valid,
  output logic             writeBack,
  output logic [7:0]       dest,
  output logic [WIDTH-1:0] writeBackData,
  output logic             zero,
  output logic             overflow
);

  exec_state_t      r_state;
  logic             r_out_valid;
  logic             r_writeback;
  logic [7:0]       r_dest;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_overflow;
  logic [7:0]       r_mul_dest;
  logic             r_mul_wb;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_b_neg;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_p;

  always_comb begin
    w_b     = selectConst ? const_in : data2;
    w_b_neg = ~w_b + WIDTH'(1);
    w_sum   = data1 + w_b;
    w_diff  = data1 + w_b_neg;
    w_res   = {WIDTH{1'b0}};
    w_ovf   = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = add_overflow(data1[WIDTH-1], w_b[WIDTH-1], w_sum[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = add_overflow(data1[WIDTH-1], w_b_neg[WIDTH-1], w_diff[WIDTH-1]);
      end
      ALU_AND:   w_res = data1 & w_b;
      ALU_OR:    w_res = data1 | w_b;
      ALU_XOR:   w_res = data1 ^ w_b;
      ALU_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(w_b))};
      ALU_PASSB: w_res = w_b;
      default:   w_res = {WIDTH{1'b0}};
    endcase
`ifdef EXEC_SAT_EN
    // On overflow A and B' share a sign, so A's sign picks the clamp direction.
    if (w_ovf) begin
      w_res = data1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_res = w_res;
    end
`endif
  end

  assign w_mul_start = (r_state == ST_IDLE) && in_valid && (alu_op == ALU_MUL);
  assign hold        = w_mul_start || ((r_state == ST_MUL) && w_mul_busy && !w_mul_done);

  exec_mul_seq #(
    .WIDTH (WIDTH),
    .ITERS (MUL_ITERS)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (w_mul_start),
    .a     (data1),
    .b     (w_b),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .p     (w_mul_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_writeback <= 1'b0;
      r_dest      <= 8'd0;
      r_data      <= {WIDTH{1'b0}};
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_mul_dest  <= 8'd0;
      r_mul_wb    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_writeback <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid && (alu_op == ALU_MUL)) begin
            r_mul_dest <= dest_in;
            r_mul_wb   <= writeBack_in;
            r_state    <= ST_MUL;
          end else if (in_valid) begin
            r_data      <= w_res;
            r_zero      <= (w_res == {WIDTH{1'b0}});
            r_overflow  <= w_ovf;
            r_dest      <= dest_in;
            r_writeback <= writeBack_in;
            r_out_valid <= 1'b1;
          end
        end
        ST_MUL: begin
          // New requests are ignored until the product lands.
          if (w_mul_done) begin
            r_data      <= w_mul_p;
            r_zero      <= (w_mul_p == {WIDTH{1'b0}});
            r_overflow  <= 1'b0;
            r_dest      <= r_mul_dest;
            r_writeback <= r_mul_wb;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign writeBack     = r_writeback;
  assign dest          = r_dest;
  assign writeBackData = r_data;
  assign zero          = r_zero;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected results, a negedge monitor pops.
// Expected values follow EXEC_SAT_EN when it is defined.
module tb_execute_stage;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [2:0]   alu_op = 3'd0;
  logic         selectConst = 1'b0;
  logic         writeBack_in = 1'b0;
  logic [7:0]   dest_in = 8'd0;
  logic [W-1:0] data1 = 8'd0;
  logic [W-1:0] data2 = 8'd0;
  logic [W-1:0] const_in = 8'd0;
  logic         hold;
  logic         out_valid;
  logic         writeBack;
  logic [7:0]   dest;
  logic [W-1:0] writeBackData;
  logic         zero;
  logic         overflow;

  execute_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
    .selectConst(selectConst), .writeBack_in(writeBack_in), .dest_in(dest_in),
    .data1(data1), .data2(data2), .const_in(const_in), .hold(hold),
    .out_valid(out_valid), .writeBack(writeBack), .dest(dest),
    .writeBackData(writeBackData), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         ovf;
    logic         wb;
    logic [7:0]   dest;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic         sc;
    logic         wb;
    logic [7:0]   dest;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] c;
    logic [W-1:0] res_wrap;
    logic [W-1:0] res_sat;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_out_valid: got data=%h dest=%0d at cycle %0d, required no output", writeBackData, dest, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (writeBackData !== e.data || zero !== e.zero || overflow !== e.ovf ||
            writeBack !== e.wb || dest !== e.dest || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL result: got data=%h z=%b ovf=%b wb=%b dest=%0d cyc=%0d, required data=%h z=%b ovf=%b wb=%b dest=%0d cyc=%0d",
                   writeBackData, zero, overflow, writeBack, dest, cyc,
                   e.data, e.zero, e.ovf, e.wb, e.dest, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic ovf, input logic wb,
                          input logic [7:0] ds, input int lat);
    exp_t e;
    e.data = d; e.zero = (d == 8'h00); e.ovf = ovf; e.wb = wb; e.dest = ds; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  // Drives one vector for a single cycle; caller is positioned just after a rising edge.
  task automatic issue(input vec_t v);
    in_valid = 1'b1; alu_op = v.op; selectConst = v.sc; writeBack_in = v.wb;
    dest_in = v.dest; data1 = v.d1; data2 = v.d2; const_in = v.c;
`ifdef EXEC_SAT_EN
    push_exp(v.res_sat, v.ovf, v.wb, v.dest, 1);
`else
    push_exp(v.res_wrap, v.ovf, v.wb, v.dest, 1);
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  vec_t vecs[13];
  int   hcnt;

  initial begin
    //           op          sc    wb    dest   d1     d2     c      wrap   sat    ovf
    vecs[0]  = '{3'b000, 1'b0, 1'b1, 8'd1,  8'h64, 8'h32, 8'h00, 8'h96, 8'h7F, 1'b1};
    vecs[1]  = '{3'b001, 1'b0, 1'b1, 8'd2,  8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{3'b001, 1'b1, 1'b1, 8'd4,  8'h0A, 8'h09, 8'h02, 8'h08, 8'h08, 1'b0};
    vecs[3]  = '{3'b101, 1'b0, 1'b1, 8'd5,  8'hFF, 8'h01, 8'h00, 8'h01, 8'h01, 1'b0};
    vecs[4]  = '{3'b010, 1'b0, 1'b1, 8'd6,  8'hF0, 8'h3C, 8'h00, 8'h30, 8'h30, 1'b0};
    vecs[5]  = '{3'b011, 1'b0, 1'b1, 8'd7,  8'hF0, 8'h0F, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vecs[6]  = '{3'b100, 1'b0, 1'b1, 8'd8,  8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{3'b111, 1'b1, 1'b1, 8'd9,  8'h11, 8'h22, 8'h5A, 8'h5A, 8'h5A, 1'b0};
    vecs[8]  = '{3'b001, 1'b0, 1'b1, 8'd10, 8'h80, 8'h01, 8'h00, 8'h7F, 8'h80, 1'b1};
    vecs[9]  = '{3'b001, 1'b0, 1'b1, 8'd11, 8'h00, 8'h80, 8'h00, 8'h80, 8'h80, 1'b0};
    vecs[10] = '{3'b000, 1'b0, 1'b0, 8'd3,  8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 1'b0};
    vecs[11] = '{3'b000, 1'b0, 1'b1, 8'd12, 8'h7F, 8'h01, 8'h00, 8'h80, 8'h7F, 1'b1};
    vecs[12] = '{3'b000, 1'b0, 1'b1, 8'd13, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h80, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {31'd0, hold}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_writeBack", {31'd0, writeBack}, 32'd0);
    check("reset_flags", {30'd0, zero, overflow}, 32'd0);
    check("reset_dest_data", {16'd0, dest, writeBackData}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i]);
      if (i == 1) begin
        @(posedge clk); #1;
        check("sub_pulse_out_valid", {31'd0, out_valid}, 32'd0);
        check("sub_idle_data_holds", {23'd0, zero, writeBackData}, {23'd0, 1'b1, 8'h00});
      end
    end
    @(posedge clk); #1;

    // MUL -3*7 with junk requests presented while it runs.
    in_valid = 1'b1; alu_op = 3'b110; selectConst = 1'b0; writeBack_in = 1'b1;
    dest_in = 8'd20; data1 = 8'hFD; data2 = 8'h07;
    push_exp(8'hEB, 1'b0, 1'b1, 8'd20, 9);
    hcnt = 0;
    @(negedge clk);
    if (hold) hcnt = hcnt + 1;
    @(posedge clk); #1;
    alu_op = 3'b000; data1 = 8'h01; data2 = 8'h01; dest_in = 8'd99;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (hold) hcnt = hcnt + 1;
      else break;
    end
    in_valid = 1'b0;
    check("mul_hold_cycles", hcnt, 32'd8);
    repeat (3) @(posedge clk);
    #1;

    // MUL aborted by reset after its fourth iteration; no result expected.
    in_valid = 1'b1; alu_op = 3'b110; data1 = 8'h05; data2 = 8'h03; dest_in = 8'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mul_mid_hold", {31'd0, hold}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_hold", {31'd0, hold}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue('{3'b000, 1'b0, 1'b1, 8'd21, 8'h01, 8'h02, 8'h00, 8'h03, 8'h03, 1'b0});

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
